// File: rtl/sync1010_frame_tx.sv
// sync1010_frame_tx: serial framer sending SYNC pattern then payload MSB first, with a 1-cycle idle gap.
// Define SYNC1010_FRAME_TX_PARITY_EN to append an even-parity bit after the payload.
module sync1010_frame_tx #(
  parameter int                SYNC_W = 4,
  parameter logic [SYNC_W-1:0] SYNC   = 4'b1010,
  parameter int                DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_tx_valid,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_tx_ready,
  output logic              o_dout,
  output logic              o_dout_en,
  output logic              o_done
);
  localparam int MAXW = SYNC_W > DATA_W ? SYNC_W : DATA_W;
  localparam int CW   = $clog2(MAXW + 1);
  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_PAR, ST_GAP} state_t;
  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_sr, w_sr_nxt;
  logic [SYNC_W-1:0] w_sync_sh;
  logic              w_dout_nxt, w_en_nxt, w_done_nxt;
`ifdef SYNC1010_FRAME_TX_PARITY_EN
  logic              r_par, w_par_nxt;
`endif
  assign o_tx_ready = r_state == ST_IDLE;
  // Outputs are registered from the next state, so r_state names the bit already on the line.
  assign w_sync_sh  = SYNC >> (r_cnt - CW'(1));
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sr_nxt    = r_sr;
    w_dout_nxt  = 1'b0;
    w_en_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
`ifdef SYNC1010_FRAME_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      ST_IDLE: if (i_tx_valid) begin
        w_state_nxt = ST_SYNC;
        w_cnt_nxt   = CW'(SYNC_W - 1);
        w_sr_nxt    = i_tx_data;
        w_dout_nxt  = SYNC[SYNC_W-1];
        w_en_nxt    = 1'b1;
`ifdef SYNC1010_FRAME_TX_PARITY_EN
        w_par_nxt   = ^i_tx_data;
`endif
      end
      ST_SYNC: begin
        w_en_nxt = 1'b1;
        if (r_cnt != '0) begin
          w_cnt_nxt  = r_cnt - CW'(1);
          w_dout_nxt = w_sync_sh[0];
        end else begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = CW'(DATA_W - 1);
          w_dout_nxt  = r_sr[DATA_W-1];
          w_sr_nxt    = r_sr << 1;
        end
      end
      ST_DATA: if (r_cnt != '0) begin
        w_en_nxt   = 1'b1;
        w_cnt_nxt  = r_cnt - CW'(1);
        w_dout_nxt = r_sr[DATA_W-1];
        w_sr_nxt   = r_sr << 1;
      end else begin
        w_cnt_nxt   = '0;
`ifdef SYNC1010_FRAME_TX_PARITY_EN
        w_state_nxt = ST_PAR;
        w_en_nxt    = 1'b1;
        w_dout_nxt  = r_par;
`else
        w_state_nxt = ST_GAP;
        w_done_nxt  = 1'b1;
`endif
      end
      ST_PAR: begin
        w_state_nxt = ST_GAP;
        w_done_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sr      <= '0;
      o_dout    <= 1'b0;
      o_dout_en <= 1'b0;
      o_done    <= 1'b0;
`ifdef SYNC1010_FRAME_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sr      <= w_sr_nxt;
      o_dout    <= w_dout_nxt;
      o_dout_en <= w_en_nxt;
      o_done    <= w_done_nxt;
`ifdef SYNC1010_FRAME_TX_PARITY_EN
      r_par     <= w_par_nxt;
`endif
    end
endmodule

// File: tb/tb_sync1010_frame_tx.sv
// tb_sync1010_frame_tx: random and directed frames checked against a per-cycle expected-line queue.
module tb_sync1010_frame_tx;
  localparam int         SW = 4;
  localparam int         DW = 8;
  localparam logic [3:0] SP = 4'b1010;
`ifdef SYNC1010_FRAME_TX_PARITY_EN
  localparam int L = SW + DW + 1;
`else
  localparam int L = SW + DW;
`endif
  logic clk, reset_n, i_tx_valid, o_tx_ready, o_dout, o_dout_en, o_done;
  logic [DW-1:0] i_tx_data;
  typedef struct packed {logic en; logic b; logic dn;} ent_t;
  ent_t q[$];
  ent_t cur;
  logic exp_rdy, prev_en;
  logic [3:0] det_sh;
  int cyc, n_chk, n_pass, n_det;
  int starts[$];
  sync1010_frame_tx #(.SYNC_W(SW), .SYNC(SP), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .i_tx_valid(i_tx_valid), .i_tx_data(i_tx_data),
    .o_tx_ready(o_tx_ready), .o_dout(o_dout), .o_dout_en(o_dout_en), .o_done(o_done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask
  function automatic void push_frame(input logic [DW-1:0] d);
    for (int i = SW - 1; i >= 0; i--) q.push_back('{1'b1, SP[i], 1'b0});
    for (int i = DW - 1; i >= 0; i--) q.push_back('{1'b1, d[i], 1'b0});
`ifdef SYNC1010_FRAME_TX_PARITY_EN
    q.push_back('{1'b1, ^d, 1'b0});
`endif
    q.push_back('{1'b0, 1'b0, 1'b1});
  endfunction
  task automatic step(input logic v, input logic [DW-1:0] d);
    i_tx_valid = v;
    i_tx_data  = d;
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      cur     = '0;
      exp_rdy = 1'b1;
    end else begin
      if (exp_rdy && v) push_frame(d);
      if (q.size() > 0) cur = q.pop_front();
      else cur = '0;
      exp_rdy = q.size() == 0 && !cur.dn;
    end
    #1;
    cyc++;
    check("dout", 32'(o_dout), 32'(cur.b));
    check("dout_en", 32'(o_dout_en), 32'(cur.en));
    check("done", 32'(o_done), 32'(cur.dn));
    check("tx_ready", 32'(o_tx_ready), 32'(exp_rdy));
    if (o_dout_en && !prev_en) starts.push_back(cyc);
    prev_en = o_dout_en;
    det_sh  = {det_sh[2:0], o_dout};
    if (det_sh == 4'b1010) n_det++;
  endtask
  task automatic async_reset_checks(input string tag);
    #1;
    check({tag, "_dout"}, 32'(o_dout), 32'd0);
    check({tag, "_dout_en"}, 32'(o_dout_en), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_ready"}, 32'(o_tx_ready), 32'd1);
  endtask
  initial begin
    reset_n = 1'b1; i_tx_valid = 1'b0; i_tx_data = '0;
    exp_rdy = 1'b1; cur = '0; prev_en = 1'b0; det_sh = '0;
    cyc = 0; n_chk = 0; n_pass = 0; n_det = 0;
    #2 reset_n = 1'b0;
    async_reset_checks("reset");
    step(1'b1, 8'h5A);
    step(1'b1, 8'hC3);
    reset_n = 1'b1;
    step(1'b0, 8'h00);
    // single frame A5
    step(1'b1, 8'hA5);
    repeat (L + 2) step(1'b0, 8'($urandom));
    // back-to-back with valid held; only the payload at the second handshake counts
    starts.delete();
    step(1'b1, 8'hFF);
    while (!exp_rdy) step(1'b1, 8'($urandom));
    step(1'b1, 8'h00);
    repeat (L + 2) step(1'b0, 8'h00);
    check("b2b_starts", 32'(starts.size()), 32'd2);
    if (starts.size() == 2) check("b2b_gap", 32'(starts[1] - starts[0]), 32'(L + 2));
    // busy frame with noisy inputs
    step(1'b1, 8'h3C);
    while (!exp_rdy) step(1'($urandom_range(0, 1)), 8'($urandom));
    repeat (2) step(1'b0, 8'h00);
    // async reset during the third payload bit
    step(1'b1, 8'hC3);
    repeat (SW + 2) step(1'b0, 8'h00);
    check("bit3_en", 32'(o_dout_en), 32'd1);
    #3 reset_n = 1'b0;
    async_reset_checks("midreset");
    step(1'b1, 8'($urandom));
    step(1'b1, 8'($urandom));
    reset_n = 1'b1;
    repeat (L + 3) step(1'b0, 8'h00);
    step(1'b1, 8'h96);
    repeat (L + 2) step(1'b0, 8'h00);
    // parity candidates
    step(1'b1, 8'h07);
    repeat (L + 2) step(1'b0, 8'h00);
    step(1'b1, 8'h03);
    repeat (L + 2) step(1'b0, 8'h00);
    // behavioural 1010 detector on the line: one hit per frame
    n_det = 0; det_sh = '0;
    repeat (3) begin
      step(1'b1, 8'h00);
      repeat (L + 1) step(1'b0, 8'h00);
    end
    repeat (3) step(1'b0, 8'h00);
    check("det_count", 32'(n_det), 32'd3);
    repeat (400) step(1'($urandom_range(0, 1)), 8'($urandom));
    repeat (L + 3) step(1'b0, 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
